// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifu_fetch_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

   localparam logic [1:0] FC_NONE     = 2'd0;
   localparam logic [1:0] FC_MISALIGN = 2'd1;
   localparam logic [1:0] FC_ACCESS   = 2'd2;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [2:0] {
      F_REQ,
      F_WAIT,
      F_ISSUE,
      F_EXEC,
      F_FAULT,
      F_HALT
   } fetch_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Multicycle instruction fetch: one outstanding imem read per instruction,
// hands the word to decode with a one-cycle valid pulse, waits for retirement.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] real_ins,
   output logic            ifu_valid,
   input  logic            idu_ready,
   input  logic [XLEN-1:0] next_pc,
   output logic            imem_arvalid,
   output logic [XLEN-1:0] imem_araddr,
   input  logic            imem_arready,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic [1:0]      imem_rresp,
   output logic            imem_rready,
   output logic            fetch_fault,
   output logic [1:0]      fault_cause,
   output logic [31:0]     fetch_count
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] ins_q, ins_d;
   logic [31:0]     count_q, count_d;
   logic            fault_q, fault_d;
   logic [1:0]      cause_q, cause_d;
   // Cause latched on entry to F_FAULT, published together with the sticky flag.
   logic [1:0]      pend_q, pend_d;
   logic            pc_aligned;

   assign pc_aligned = (pc_q[1:0] == 2'b00);

   // Next-state logic for the fetch FSM and its datapath registers.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ins_d   = ins_q;
      count_d = count_q;
      fault_d = fault_q;
      cause_d = cause_q;
      pend_d  = pend_q;
      case (state_q)
         F_REQ: begin
            if (!pc_aligned) begin
               pend_d  = FC_MISALIGN;
               state_d = F_FAULT;
            end else if (imem_arready) begin
               state_d = F_WAIT;
            end
         end
         F_WAIT: begin
            if (imem_rvalid) begin
               if (imem_rresp != RESP_OKAY) begin
                  pend_d  = FC_ACCESS;
                  state_d = F_FAULT;
               end else begin
                  ins_d   = imem_rdata;
                  state_d = F_ISSUE;
               end
            end
         end
         F_ISSUE: state_d = F_EXEC;
         F_EXEC: begin
            if (idu_ready) begin
               pc_d    = next_pc;
               count_d = count_q + 32'd1;
               state_d = F_REQ;
            end
         end
         F_FAULT: begin
            fault_d = 1'b1;
            cause_d = pend_q;
            state_d = F_HALT;
         end
         F_HALT:  state_d = F_HALT;
         default: state_d = F_HALT;
      endcase
   end

   // State and datapath registers, asynchronously reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= F_REQ;
         pc_q    <= RESET_PC;
         ins_q   <= '0;
         count_q <= '0;
         fault_q <= 1'b0;
         cause_q <= FC_NONE;
         pend_q  <= FC_NONE;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ins_q   <= ins_d;
         count_q <= count_d;
         fault_q <= fault_d;
         cause_q <= cause_d;
         pend_q  <= pend_d;
      end
   end

   assign pc          = pc_q;
   assign real_ins    = ins_q;
   assign imem_araddr = pc_q;
   assign fetch_fault = fault_q;
   assign fault_cause = cause_q;
   assign fetch_count = count_q;
   assign ifu_valid   = (state_q == F_ISSUE);
   assign imem_rready = (state_q == F_WAIT);
   // Reset parks the FSM in F_REQ, so the request must be masked while rst is held low.
   assign imem_arvalid = rst && (state_q == F_REQ) && pc_aligned;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus randomized fetch loop.
module tb_ifu_fetch;
   import ifu_fetch_pkg::*;

   localparam logic [31:0] RPC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc, real_ins, next_pc, imem_araddr, imem_rdata, fetch_count;
   logic        ifu_valid, idu_ready, imem_arvalid, imem_arready, imem_rvalid, imem_rready;
   logic        fetch_fault;
   logic [1:0]  imem_rresp, fault_cause;

   int errors = 0;
   int checks = 0;

   // Reference model: architectural view of the fetch stage.
   logic [31:0] m_pc, m_ins, m_count;
   logic        m_fault;
   logic [1:0]  m_cause;

   always #5 clk = ~clk;

   ifu_fetch #(.XLEN(32), .RESET_PC(RPC)) dut (
      .clk          (clk),
      .rst          (rst),
      .pc           (pc),
      .real_ins     (real_ins),
      .ifu_valid    (ifu_valid),
      .idu_ready    (idu_ready),
      .next_pc      (next_pc),
      .imem_arvalid (imem_arvalid),
      .imem_araddr  (imem_araddr),
      .imem_arready (imem_arready),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .imem_rresp   (imem_rresp),
      .imem_rready  (imem_rready),
      .fetch_fault  (fetch_fault),
      .fault_cause  (fault_cause),
      .fetch_count  (fetch_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_pc"}, pc, m_pc);
      chk({tag, "_real_ins"}, real_ins, m_ins);
      chk({tag, "_count"}, fetch_count, m_count);
      chk({tag, "_fault"}, {31'b0, fetch_fault}, {31'b0, m_fault});
      chk({tag, "_cause"}, {30'b0, fault_cause}, {30'b0, m_cause});
   endtask

   task automatic model_reset();
      m_pc    = RPC;
      m_ins   = '0;
      m_count = '0;
      m_fault = 1'b0;
      m_cause = FC_NONE;
   endtask

   // Hold rst low for two cycles starting at a negedge, checking outputs in reset.
   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         #1;
         chk_model("rst");
         chk("rst_ifu_valid", {31'b0, ifu_valid}, 32'd0);
         chk("rst_arvalid", {31'b0, imem_arvalid}, 32'd0);
         chk("rst_rready", {31'b0, imem_rready}, 32'd0);
         @(negedge clk);
      end
      rst = 1'b1;
   endtask

   // One full fetch from F_REQ; returns at the negedge of F_ISSUE+1 (ok) or F_FAULT.
   task automatic fetch(input logic [31:0] data, input logic [1:0] resp, input int ar_dly,
                        input int r_dly, input bit poke);
      for (int i = 0; i <= ar_dly; i++) begin
         @(negedge clk);
         chk("req_arvalid", {31'b0, imem_arvalid}, 32'd1);
         chk("req_araddr", imem_araddr, m_pc);
         chk("req_rready", {31'b0, imem_rready}, 32'd0);
         chk("req_ifu_valid", {31'b0, ifu_valid}, 32'd0);
         imem_arready = (i == ar_dly);
         // Stray read data while not in F_WAIT must be ignored.
         imem_rvalid  = 1'($urandom_range(0, 1));
         imem_rdata   = $urandom;
         imem_rresp   = 2'($urandom);
      end
      @(negedge clk);
      imem_arready = 1'b0;
      for (int i = 0; i <= r_dly; i++) begin
         if (i > 0) @(negedge clk);
         chk("wait_rready", {31'b0, imem_rready}, 32'd1);
         chk("wait_arvalid", {31'b0, imem_arvalid}, 32'd0);
         chk("wait_ifu_valid", {31'b0, ifu_valid}, 32'd0);
         imem_rvalid = (i == r_dly);
         imem_rdata  = (i == r_dly) ? data : $urandom;
         imem_rresp  = (i == r_dly) ? resp : 2'($urandom);
         idu_ready   = poke;
         next_pc     = $urandom;
      end
      @(negedge clk);
      imem_rvalid = 1'b0;
      idu_ready   = 1'b0;
      if (resp == RESP_OKAY) begin
         m_ins = data;
         chk("issue_ifu_valid", {31'b0, ifu_valid}, 32'd1);
         chk_model("issue");
         idu_ready = poke;
         next_pc   = $urandom;
         @(negedge clk);
         idu_ready = 1'b0;
         chk("exec_ifu_valid", {31'b0, ifu_valid}, 32'd0);
         chk("exec_arvalid", {31'b0, imem_arvalid}, 32'd0);
         chk_model("exec");
      end else begin
         chk("fault_ifu_valid", {31'b0, ifu_valid}, 32'd0);
         m_fault = 1'b1;
         m_cause = FC_ACCESS;
      end
   endtask

   // Idle in F_EXEC for a while, then retire with the given next PC.
   task automatic retire(input logic [31:0] npc, input int idle);
      for (int i = 0; i < idle; i++) begin
         @(negedge clk);
         chk("hold_ifu_valid", {31'b0, ifu_valid}, 32'd0);
         chk("hold_arvalid", {31'b0, imem_arvalid}, 32'd0);
         chk_model("hold");
      end
      idu_ready = 1'b1;
      next_pc   = npc;
      @(negedge clk);
      idu_ready = 1'b0;
      next_pc   = $urandom;
      m_pc      = npc;
      m_count   = m_count + 32'd1;
      chk_model("retire");
   endtask

   // Terminal state: nothing issues, fault stays sticky.
   task automatic chk_halt(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         idu_ready   = 1'($urandom_range(0, 1));
         imem_rvalid = 1'($urandom_range(0, 1));
         chk("halt_ifu_valid", {31'b0, ifu_valid}, 32'd0);
         chk("halt_arvalid", {31'b0, imem_arvalid}, 32'd0);
         chk("halt_rready", {31'b0, imem_rready}, 32'd0);
         chk_model("halt");
      end
      idu_ready   = 1'b0;
      imem_rvalid = 1'b0;
   endtask

   initial begin
      logic [31:0] npc, prev_ins;
      rst          = 1'b1;
      idu_ready    = 1'b0;
      next_pc      = '0;
      imem_arready = 1'b0;
      imem_rvalid  = 1'b0;
      imem_rdata   = '0;
      imem_rresp   = RESP_OKAY;
      @(negedge clk);
      do_reset();

      // Zero-wait first fetch: ifu_valid in the third cycle after reset release.
      fetch(32'h0000_0413, RESP_OKAY, 0, 0, 1'b0);
      retire(32'h8000_0004, 3);

      // Slow arready, idu_ready poked in F_WAIT and F_ISSUE.
      fetch($urandom, RESP_OKAY, 5, 2, 1'b1);
      retire(32'hFFFF_FFFC, 1);
      fetch($urandom, RESP_OKAY, 1, 1, 1'b0);

      // Randomized fetch/retire loop.
      for (int n = 0; n < 25; n++) begin
         npc = {$urandom(), 2'b00} >> 0;
         npc[1:0] = 2'b00;
         retire(npc, $urandom_range(0, 3));
         fetch($urandom, RESP_OKAY, $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)));
      end

      // Access fault at 0x80000008: real_ins keeps the previous word.
      retire(32'h8000_0008, 0);
      prev_ins = m_ins;
      fetch($urandom, 2'b10, 0, 1, 1'b0);
      chk("access_real_ins_kept", real_ins, prev_ins);
      chk_halt(20);

      // Misaligned next PC: no request, cause 1.
      do_reset();
      fetch($urandom, RESP_OKAY, 0, 0, 1'b0);
      retire(32'h8000_0002, 0);
      chk("misalign_arvalid", {31'b0, imem_arvalid}, 32'd0);
      @(negedge clk);
      chk("misalign_f_arvalid", {31'b0, imem_arvalid}, 32'd0);
      m_fault = 1'b1;
      m_cause = FC_MISALIGN;
      chk_halt(20);

      // Reset while a read is outstanding.
      do_reset();
      fetch($urandom, RESP_OKAY, 0, 0, 1'b0);
      retire(32'h8000_0010, 0);
      @(negedge clk);
      chk("mid_araddr", imem_araddr, 32'h8000_0010);
      imem_arready = 1'b1;
      @(negedge clk);
      imem_arready = 1'b0;
      chk("mid_wait_rready", {31'b0, imem_rready}, 32'd1);
      do_reset();
      fetch($urandom, RESP_OKAY, 0, 0, 1'b0);
      chk("post_rst_count", fetch_count, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
